// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register indices, ExcCode values and Status/Cause field positions.
package cp0_pkg;

  localparam logic [4:0] COUNT   = 5'd9;
  localparam logic [4:0] COMPARE = 5'd11;
  localparam logic [4:0] STATUS  = 5'd12;
  localparam logic [4:0] CAUSE   = 5'd13;
  localparam logic [4:0] EPC     = 5'd14;

  localparam logic [4:0] INT     = 5'd0;
  localparam logic [4:0] SYSCALL = 5'd8;
  localparam logic [4:0] BREAK   = 5'd9;
  localparam logic [4:0] TEQ     = 5'd13;

  localparam int unsigned IE           = 0;
  localparam int unsigned IP_BASE      = 8;
  localparam int unsigned TI           = 15;
  localparam int unsigned NOVF         = 30;
  localparam int unsigned EXC_LSB      = 2;
  localparam int unsigned STATUS_SHIFT = 5;

endpackage

// File: rtl/cp0_epc_stack.sv
// Saturating EPC stack: entry 0 is the top; a push when full drops the oldest entry.
module cp0_epc_stack #(
  parameter int unsigned DEPTH = 3,
  localparam int unsigned DW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          wr_top,
  input  logic [31:0]   din,
  output logic [31:0]   top,
  output logic [DW-1:0] depth
);

  logic [31:0]   ent_q [DEPTH];
  logic [31:0]   ent_d [DEPTH];
  logic [DW-1:0] depth_q, depth_d;

  always_comb begin
    ent_d   = ent_q;
    depth_d = depth_q;
    if (push) begin
      for (int i = DEPTH - 1; i > 0; i--) ent_d[i] = ent_q[i-1];
      ent_d[0] = din;
      if (depth_q != DW'(DEPTH)) depth_d = depth_q + DW'(1);
    end else if (pop && depth_q != '0) begin
      for (int i = 0; i < DEPTH - 1; i++) ent_d[i] = ent_q[i+1];
      ent_d[DEPTH-1] = '0;
      depth_d        = depth_q - DW'(1);
    end else if (wr_top) begin
      ent_d[0] = din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      depth_q <= '0;
    end else begin
      ent_q   <= ent_d;
      depth_q <= depth_d;
    end
  end

  assign top   = ent_q[0];
  assign depth = depth_q;

endmodule

// File: rtl/cp0_nested.sv
// MIPS CP0 with nested EPC stack, Status shift nesting and synchronised IRQs.
// Optional Count/Compare timer enabled by defining CP0_TIMER_EN.
module cp0_nested
  import cp0_pkg::*;
#(
  parameter logic [31:0] VECTOR_ADDR = 32'h00400004,
  parameter int unsigned NEST_DEPTH  = 3,
  parameter int unsigned N_IRQ       = 6,
  localparam int unsigned DW         = $clog2(NEST_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             exception,
  input  logic             mfc0,
  input  logic             mtc0,
  input  logic             eret,
  input  logic [31:0]      pc,
  input  logic [4:0]       rd,
  input  logic [31:0]      wdata,
  input  logic [4:0]       cause,
  input  logic [N_IRQ-1:0] irq,
  output logic [31:0]      rdata,
  output logic [31:0]      status,
  output logic [31:0]      exc_addr,
  output logic             int_pending,
  output logic [DW-1:0]    nest_depth
);

  logic [31:0]      regs_q [32];
  logic [31:0]      regs_d [32];
  logic [N_IRQ-1:0] irq_s1_q;
  logic             int_pending_q, int_pending_d;
  logic [31:0]      epc_top;
  logic [DW-1:0]    depth;
  logic             ip_sw_wr, ovf;

  cp0_epc_stack #(
    .DEPTH (NEST_DEPTH)
  ) u_epc_stack (
    .clk    (clk),
    .rst    (rst),
    .push   (exception),
    .pop    (eret && !exception),
    .wr_top (mtc0 && rd == EPC && !exception),
    .din    (exception ? pc : wdata),
    .top    (epc_top),
    .depth  (depth)
  );

  assign ip_sw_wr = mtc0 && rd == CAUSE && !exception;
  assign ovf      = exception && depth == DW'(NEST_DEPTH);

  always_comb begin
    regs_d = regs_q;
    if (mtc0 && rd != EPC && rd != CAUSE && !(exception && rd == STATUS)) begin
      regs_d[rd] = wdata;
    end
    if (ip_sw_wr) begin
      regs_d[CAUSE][9:8]  = wdata[9:8];
      regs_d[CAUSE][NOVF] = wdata[NOVF];
    end
    // The second synchroniser stage is the Cause.IP bit itself.
    for (int i = 0; i < N_IRQ; i++) begin
      if (!(ip_sw_wr && IP_BASE + i < 10)) regs_d[CAUSE][IP_BASE+i] = irq_s1_q[i];
    end
`ifdef CP0_TIMER_EN
    if (!(mtc0 && rd == COUNT)) regs_d[COUNT] = regs_q[COUNT] + 32'd1;
    if (mtc0 && rd == COMPARE) begin
      regs_d[CAUSE][TI] = 1'b0;
    end else if (regs_d[COUNT] == regs_q[COMPARE] && regs_q[COMPARE] != '0) begin
      regs_d[CAUSE][TI] = 1'b1;
    end else begin
      regs_d[CAUSE][TI] = regs_q[CAUSE][TI] | regs_d[CAUSE][TI];
    end
`endif
    if (exception) begin
      regs_d[STATUS]               = regs_q[STATUS] << STATUS_SHIFT;
      regs_d[CAUSE][EXC_LSB+:5]    = cause;
      if (ovf) regs_d[CAUSE][NOVF] = 1'b1;
    end else if (eret && depth != '0) begin
      regs_d[STATUS] = regs_q[STATUS] >> STATUS_SHIFT;
    end
    regs_d[EPC] = '0;
  end

  assign int_pending_d = regs_q[STATUS][IE] && (depth == '0) &&
                         |(regs_q[CAUSE][15:8] & regs_q[STATUS][15:8]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
      irq_s1_q      <= '0;
      int_pending_q <= 1'b0;
    end else begin
      regs_q        <= regs_d;
      irq_s1_q      <= irq;
      int_pending_q <= int_pending_d;
    end
  end

  always_comb begin
    rdata = '0;
    if (mfc0) rdata = (rd == EPC) ? epc_top : regs_q[rd];
  end

  assign status      = regs_q[STATUS];
  assign exc_addr    = eret ? epc_top : VECTOR_ADDR;
  assign int_pending = int_pending_q;
  assign nest_depth  = depth;

endmodule

// File: tb/tb_cp0_nested.sv
// Directed bench for cp0_nested: nesting, overflow, collisions, reset, interrupts and timer.
module tb_cp0_nested;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        exception = 1'b0, mfc0 = 1'b0, mtc0 = 1'b0, eret = 1'b0;
  logic [31:0] pc = '0, wdata = '0;
  logic [4:0]  rd = '0, cause = '0;
  logic [5:0]  irq = '0;
  logic [31:0] rdata, status, exc_addr;
  logic        int_pending;
  logic [1:0]  nest_depth;
  logic [31:0] v;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [31:0] VEC = 32'h00400004;

  cp0_nested dut (
    .clk         (clk),
    .rst         (rst),
    .exception   (exception),
    .mfc0        (mfc0),
    .mtc0        (mtc0),
    .eret        (eret),
    .pc          (pc),
    .rd          (rd),
    .wdata       (wdata),
    .cause       (cause),
    .irq         (irq),
    .rdata       (rdata),
    .status      (status),
    .exc_addr    (exc_addr),
    .int_pending (int_pending),
    .nest_depth  (nest_depth)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_cp0(input logic [4:0] r, input logic [31:0] d);
    mtc0 = 1'b1; rd = r; wdata = d;
    tick();
    mtc0 = 1'b0;
  endtask

  task automatic rd_cp0(input logic [4:0] r, output logic [31:0] val);
    mfc0 = 1'b1; rd = r;
    #1 val = rdata;
    mfc0 = 1'b0;
  endtask

  task automatic take_exc(input logic [31:0] p, input logic [4:0] c);
    exception = 1'b1; pc = p; cause = c;
    tick();
    exception = 1'b0;
  endtask

  task automatic do_eret(input string tag, input logic [31:0] exp_addr);
    eret = 1'b1;
    #1 check(tag, exc_addr, exp_addr);
    tick();
    eret = 1'b0;
  endtask

  initial begin
    // reset state
    #2;
    check("rst_status", status, 32'h0);
    check("rst_exc_addr", exc_addr, VEC);
    check("rst_depth", nest_depth, 32'h0);
    check("rst_int_pending", int_pending, 32'h0);
    #10 rst = 1'b1;
    tick();

    // nesting
    wr_cp0(5'd12, 32'h1F);
    take_exc(32'h100, 5'd8);
    take_exc(32'h200, 5'd9);
    check("nest2_status", status, 32'h7C00);
    take_exc(32'h300, 5'd13);
    check("nest3_status", status, 32'h000F_8000);
    check("nest3_depth", nest_depth, 32'd3);
    rd_cp0(5'd13, v);
    check("nest3_cause", v, 32'h34);
    do_eret("eret1_addr", 32'h300);
    do_eret("eret2_addr", 32'h200);
    do_eret("eret3_addr", 32'h100);
    check("unnest_status", status, 32'h1F);
    check("unnest_depth", nest_depth, 32'd0);

    // overflow: oldest entry dropped
    take_exc(32'h1000, 5'd0);
    take_exc(32'h2000, 5'd0);
    take_exc(32'h3000, 5'd0);
    take_exc(32'h4000, 5'd0);
    check("ovf_depth", nest_depth, 32'd3);
    rd_cp0(5'd13, v);
    check("ovf_cause", v, 32'h4000_0000);
    do_eret("ovf_eret1", 32'h4000);
    do_eret("ovf_eret2", 32'h3000);
    do_eret("ovf_eret3", 32'h2000);
    do_eret("ovf_eret4", 32'h0);
    check("ovf_depth_empty", nest_depth, 32'd0);
    check("ovf_status", status, 32'h3E0);
    wr_cp0(5'd13, 32'h0);
    rd_cp0(5'd13, v);
    check("novf_clear", v, 32'h0);
    wr_cp0(5'd14, 32'hABC);
    do_eret("eret_empty_top", 32'hABC);
    check("eret_empty_depth", nest_depth, 32'd0);

    // collisions
    wr_cp0(5'd12, 32'h1);
    eret = 1'b1;
    take_exc(32'h500, 5'd8);
    eret = 1'b0;
    check("exc_eret_depth", nest_depth, 32'd1);
    check("exc_eret_status", status, 32'h20);
    mtc0 = 1'b1; rd = 5'd12; wdata = 32'hFFFF;
    take_exc(32'h600, 5'd9);
    mtc0 = 1'b0;
    check("exc_mtc0_status", status, 32'h400);
    mtc0 = 1'b1; rd = 5'd4; wdata = 32'hDEAD;
    take_exc(32'h700, 5'd9);
    mtc0 = 1'b0;
    rd_cp0(5'd4, v);
    check("exc_mtc0_reg4", v, 32'hDEAD);

    // asynchronous reset mid-run, away from any clock edge
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("async_rst_status", status, 32'h0);
    check("async_rst_exc_addr", exc_addr, VEC);
    check("async_rst_depth", nest_depth, 32'd0);
    #2 rst = 1'b1;
    tick();

    // interrupt path
    wr_cp0(5'd12, 32'h0401);
    irq = 6'b000100;
    tick();
    rd_cp0(5'd13, v);
    check("irq_cause_1clk", v, 32'h0);
    tick();
    rd_cp0(5'd13, v);
    check("irq_cause_2clk", v, 32'h400);
    check("irq_pend_2clk", int_pending, 32'h0);
    tick();
    check("irq_pend_3clk", int_pending, 32'h1);
    wr_cp0(5'd12, 32'h0400);
    tick();
    check("irq_pend_ie0", int_pending, 32'h0);
    irq = '0;
    tick();

`ifdef CP0_TIMER_EN
    wr_cp0(5'd11, 32'd20);
    wr_cp0(5'd9, 32'd0);
    repeat (19) tick();
    rd_cp0(5'd13, v);
    check("timer_ti_early", v[15], 32'h0);
    tick();
    rd_cp0(5'd13, v);
    check("timer_ti_set", v[15], 32'h1);
    wr_cp0(5'd11, 32'd50);
    rd_cp0(5'd13, v);
    check("timer_ti_clear", v[15], 32'h0);
`else
    wr_cp0(5'd9, 32'h1234);
    repeat (5) tick();
    rd_cp0(5'd9, v);
    check("count_static", v, 32'h1234);
    rd_cp0(5'd13, v);
    check("no_timer_ti", v[15], 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
